ccd_capture_window: RTL and testbench

- Parametrised successor of the camera capture stage. Sits between the registered sensor pins (DATA/FVAL/LVAL) and RAW2RGB.
- Adds start/stop arming with whole-frame granularity, a runtime crop window, power-of-two decimation, and a completed-frame counter.
- Emits cropped/decimated pixels with window-relative coordinates, so downstream Bayer/SDRAM logic sees a smaller image.

---
 rtl/ccd_capture_window.sv | 231 +++++++++++++++++++++++
 tb/tb_ccd_capture_window.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_capture_window.sv
// ccd_capture_window: camera capture stage with frame-granular start/stop arming,
// a runtime crop window, power-of-two decimation and a completed-frame counter.
// Optional per-frame pixel statistics are enabled by defining CCD_CAPTURE_WINDOW_STATS_EN;
// without it oFRAME_PIX is tied to zero and the port list is unchanged.
module ccd_capture_window #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FRM_W  = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iSTART,
    input  logic              iEND,
    input  logic [CNT_W-1:0]  iWIN_X0,
    input  logic [CNT_W-1:0]  iWIN_Y0,
    input  logic [CNT_W-1:0]  iWIN_W,
    input  logic [CNT_W-1:0]  iWIN_H,
    input  logic [1:0]        iDEC,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [FRM_W-1:0]  oFrame_Cont,
    output logic              oBUSY,
    output logic [31:0]       oFRAME_PIX
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    state_t           state;
    logic             prev_fval;
    logic             prev_lval;
    logic             prev_start;
    logic             prev_end;
    logic             stop_pend;

    logic             start_edge;
    logic             end_edge;
    logic             frame_start;
    logic             frame_end;
    logic             line_end;
    logic             stop_req;

    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] win_x0;
    logic [CNT_W-1:0] win_y0;
    logic [CNT_W-1:0] win_w;
    logic [CNT_W-1:0] win_h;
    logic [1:0]       win_dec;

    logic [CNT_W:0]   x_lim;
    logic [CNT_W:0]   y_lim;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;
    logic [CNT_W-1:0] dec_mask;
    logic             in_x;
    logic             in_y;
    logic             on_grid;
    logic             hit;

    assign start_edge  = iSTART & ~prev_start;
    assign end_edge    = iEND & ~prev_end;
    assign frame_start = iFVAL & ~prev_fval;
    assign frame_end   = ~iFVAL & prev_fval;
    assign line_end    = ~iLVAL & prev_lval;

    // A stop takes effect at frame end if requested now or pending and not cancelled by START.
    assign stop_req = end_edge | (stop_pend & ~start_edge);

    // Window limits in one extra bit so origin + size never wraps.
    assign x_lim    = {1'b0, win_x0} + {1'b0, win_w};
    assign y_lim    = {1'b0, win_y0} + {1'b0, win_h};
    assign dx       = x_cnt - win_x0;
    assign dy       = y_cnt - win_y0;
    assign dec_mask = ~({CNT_W{1'b1}} << win_dec);
    assign in_x     = (x_cnt >= win_x0) && ({1'b0, x_cnt} < x_lim);
    assign in_y     = (y_cnt >= win_y0) && ({1'b0, y_cnt} < y_lim);
    assign on_grid  = ((dx & dec_mask) == '0) && ((dy & dec_mask) == '0);
    assign hit      = iLVAL && (state == S_FRAME) && in_x && in_y && on_grid;

    // Previous-cycle copies for edge detection; set high so levels held at reset are not edges.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            prev_fval  <= 1'b1;
            prev_lval  <= 1'b1;
            prev_start <= 1'b1;
            prev_end   <= 1'b1;
        end else begin
            prev_fval  <= iFVAL;
            prev_lval  <= iLVAL;
            prev_start <= iSTART;
            prev_end   <= iEND;
        end
    end

    // Arming state machine; window and decimation are latched at the frame start that enters FRAME.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= S_IDLE;
            oBUSY     <= 1'b0;
            stop_pend <= 1'b0;
            win_x0    <= '0;
            win_y0    <= '0;
            win_w     <= '0;
            win_h     <= '0;
            win_dec   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge && !end_edge) begin
                        state <= S_WAIT;
                        oBUSY <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (end_edge) begin
                        state <= S_IDLE;
                        oBUSY <= 1'b0;
                    end else if (frame_start) begin
                        state   <= S_FRAME;
                        win_x0  <= iWIN_X0;
                        win_y0  <= iWIN_Y0;
                        win_w   <= iWIN_W;
                        win_h   <= iWIN_H;
                        win_dec <= iDEC;
                    end
                end
                S_FRAME: begin
                    if (frame_end) begin
                        stop_pend <= 1'b0;
                        if (stop_req) begin
                            state <= S_IDLE;
                            oBUSY <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (end_edge) begin
                        stop_pend <= 1'b1;
                    end else if (start_edge) begin
                        stop_pend <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    oBUSY     <= 1'b0;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Raw pixel position within the frame, saturating at all-ones.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state == S_FRAME) begin
            if (iLVAL) begin
                if (x_cnt != '1) begin
                    x_cnt <= x_cnt + CNT_W'(1);
                end
            end else if (line_end) begin
                x_cnt <= '0;
                if (y_cnt != '1) begin
                    y_cnt <= y_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Registered pixel output; data and coordinates hold when no pixel passes.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDVAL   <= 1'b0;
            oDATA   <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else if (hit) begin
            oDVAL   <= 1'b1;
            oDATA   <= iDATA;
            oX_Cont <= dx >> win_dec;
            oY_Cont <= dy >> win_dec;
        end else begin
            oDVAL   <= 1'b0;
        end
    end

    // Completed captured frames; wraps naturally and survives stop.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oFrame_Cont <= '0;
        end else if ((state == S_FRAME) && frame_end) begin
            oFrame_Cont <= oFrame_Cont + FRM_W'(1);
        end
    end

`ifdef CCD_CAPTURE_WINDOW_STATS_EN
    logic [31:0] pix_cnt;

    // Count emitted pixels per frame; publish the total at frame end including that cycle's pixel.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pix_cnt    <= '0;
            oFRAME_PIX <= '0;
        end else begin
            if (frame_start) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + 32'(oDVAL);
            end
            if ((state == S_FRAME) && frame_end) begin
                oFRAME_PIX <= pix_cnt + 32'(oDVAL);
            end
        end
    end
`else
    assign oFRAME_PIX = '0;
`endif

endmodule

// File: tb/tb_ccd_capture_window.sv
// Testbench for ccd_capture_window: random pixel data and windows checked against a
// coordinate-level model of which raw pixels fall inside the decimated crop window.
module tb_ccd_capture_window;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int FRM_W  = 32;
    localparam int FW     = 24;
    localparam int FH     = 16;

    logic              iCLK;
    logic              iRST;
    logic [DATA_W-1:0] iDATA;
    logic              iFVAL;
    logic              iLVAL;
    logic              iSTART;
    logic              iEND;
    logic [CNT_W-1:0]  iWIN_X0;
    logic [CNT_W-1:0]  iWIN_Y0;
    logic [CNT_W-1:0]  iWIN_W;
    logic [CNT_W-1:0]  iWIN_H;
    logic [1:0]        iDEC;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic [FRM_W-1:0]  oFrame_Cont;
    logic              oBUSY;
    logic [31:0]       oFRAME_PIX;

    ccd_capture_window #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .FRM_W (FRM_W)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iSTART     (iSTART),
        .iEND       (iEND),
        .iWIN_X0    (iWIN_X0),
        .iWIN_Y0    (iWIN_Y0),
        .iWIN_W     (iWIN_W),
        .iWIN_H     (iWIN_H),
        .iDEC       (iDEC),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oBUSY      (oBUSY),
        .oFRAME_PIX (oFRAME_PIX)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        int                ox;
        int                oy;
        int                cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t obs_q[$];
    pix_t mon_p;

    int n_checks;
    int n_pass;
    int cyc;
    int exp_frames;
    int last_cnt;
    int m_x0, m_y0, m_w, m_h, m_dec;
    int n_x0, n_y0, n_w, n_h, n_dec;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Collect every emitted pixel with the cycle it appeared in.
    always @(negedge iCLK) begin
        if (oDVAL === 1'b1) begin
            mon_p.d   = oDATA;
            mon_p.ox  = int'(oX_Cont);
            mon_p.oy  = int'(oY_Cont);
            mon_p.cyc = cyc;
            obs_q.push_back(mon_p);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_win(input int x0, input int y0, input int w, input int h, input int dec);
        m_x0 = x0; m_y0 = y0; m_w = w; m_h = h; m_dec = dec;
        iWIN_X0 = CNT_W'(x0);
        iWIN_Y0 = CNT_W'(y0);
        iWIN_W  = CNT_W'(w);
        iWIN_H  = CNT_W'(h);
        iDEC    = 2'(dec);
    endtask

    task automatic arm();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        step();
    endtask

    // Drive one frame; when cap is set, queue the pixels the crop window should keep.
    task automatic drive_frame(input bit cap, input int end_line, input int chg_line);
        int st;
        st = 1 << m_dec;
        step(); iFVAL = 1'b1;
        step();
        step();
        for (int y = 0; y < FH; y++) begin
            if (y == chg_line) begin
                iWIN_X0 = CNT_W'(n_x0);
                iWIN_Y0 = CNT_W'(n_y0);
                iWIN_W  = CNT_W'(n_w);
                iWIN_H  = CNT_W'(n_h);
                iDEC    = 2'(n_dec);
            end
            if (y == end_line) iEND = 1'b1;
            if (y == end_line + 2) iEND = 1'b0;
            for (int x = 0; x < FW; x++) begin
                step();
                iLVAL = 1'b1;
                iDATA = DATA_W'($urandom);
                if (cap && x >= m_x0 && x < m_x0 + m_w && y >= m_y0 && y < m_y0 + m_h &&
                    (x - m_x0) % st == 0 && (y - m_y0) % st == 0) begin
                    exp_q.push_back('{iDATA, (x - m_x0) / st, (y - m_y0) / st, cyc});
                end
            end
            step(); iLVAL = 1'b0;
            step();
        end
        step(); iFVAL = 1'b0; iEND = 1'b0;
        repeat (4) step();
    endtask

    // Compare observed against expected pixels (data, coordinates, one-cycle latency).
    function automatic int pix_diff(output string msg);
        int bad;
        bad = 0;
        msg = "";
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            msg = $sformatf("pixel count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].ox != exp_q[i].ox ||
                obs_q[i].oy != exp_q[i].oy || obs_q[i].cyc != exp_q[i].cyc + 1) begin
                if (bad == 0)
                    msg = $sformatf("idx %0d got d=%h x=%0d y=%0d cyc=%0d want d=%h x=%0d y=%0d cyc=%0d",
                                    i, obs_q[i].d, obs_q[i].ox, obs_q[i].oy, obs_q[i].cyc,
                                    exp_q[i].d, exp_q[i].ox, exp_q[i].oy, exp_q[i].cyc + 1);
                bad++;
            end
        end
        return bad;
    endfunction

    function automatic int stats_exp(input int n);
`ifdef CCD_CAPTURE_WINDOW_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic test_reset();
        iRST = 1'b1; iFVAL = 1'b1; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
        iDATA = '0;
        set_win(0, 0, 0, 0, 0);
        repeat (3) step();
        n_checks++;
        if ({oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY, oFRAME_PIX} !== '0)
            $display("FAIL reset_outputs: got dval=%b data=%h x=%0d y=%0d frm=%0d busy=%b pix=%0d want all 0",
                     oDVAL, oDATA, oX_Cont, oY_Cont, oFrame_Cont, oBUSY, oFRAME_PIX);
        else n_pass++;
        iRST = 1'b0;
        step();
        step();
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", oBUSY);
        else n_pass++;
    endtask

    task automatic test_arm_mid_frame();
        string msg;
        int nb;
        set_win(0, 0, FW, FH, 0);
        for (int l = 0; l < 3; l++) begin
            for (int x = 0; x < FW; x++) begin
                step(); iLVAL = 1'b1; iDATA = DATA_W'($urandom);
            end
            step(); iLVAL = 1'b0;
            if (l == 0) begin
                iSTART = 1'b1;
                step();
                n_checks++;
                if (oBUSY !== 1'b1) $display("FAIL busy_after_start: got %b want 1", oBUSY);
                else n_pass++;
                iSTART = 1'b0;
            end
        end
        step(); iFVAL = 1'b0;
        repeat (4) step();
        n_checks++;
        if (obs_q.size() != 0 || oFrame_Cont !== 0)
            $display("FAIL partial_frame: got %0d pixels frm=%0d want 0 pixels frm=0", obs_q.size(), oFrame_Cont);
        else n_pass++;
        obs_q.delete();
        drive_frame(1'b1, -1, -1);
        exp_frames++;
        last_cnt = exp_q.size();
        nb = pix_diff(msg);
        n_checks++;
        if (nb !== 0) $display("FAIL full_window_pixels: %s", msg);
        else n_pass++;
        n_checks++;
        if (oX_Cont !== CNT_W'(FW - 1) || oY_Cont !== CNT_W'(FH - 1))
            $display("FAIL full_window_last: got x=%0d y=%0d want x=%0d y=%0d", oX_Cont, oY_Cont, FW - 1, FH - 1);
        else n_pass++;
        n_checks++;
        if (oFrame_Cont !== FRM_W'(exp_frames) || oFRAME_PIX !== 32'(stats_exp(last_cnt)))
            $display("FAIL full_window_counts: got frm=%0d pix=%0d want frm=%0d pix=%0d",
                     oFrame_Cont, oFRAME_PIX, exp_frames, stats_exp(last_cnt));
        else n_pass++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_window_dec();
        string msg;
        int nb;
        set_win(5, 3, 12, 8, 1);
        drive_frame(1'b1, -1, -1);
        exp_frames++;
        last_cnt = exp_q.size();
        nb = pix_diff(msg);
        n_checks++;
        if (nb !== 0 || last_cnt != 24) $display("FAIL window_dec_pixels: %s (model count %0d want 24)", msg, last_cnt);
        else n_pass++;
        n_checks++;
        if (oFrame_Cont !== FRM_W'(exp_frames) || oFRAME_PIX !== 32'(stats_exp(last_cnt)))
            $display("FAIL window_dec_counts: got frm=%0d pix=%0d want frm=%0d pix=%0d",
                     oFrame_Cont, oFRAME_PIX, exp_frames, stats_exp(last_cnt));
        else n_pass++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_window_change();
        string msg;
        int nb;
        set_win(2, 2, 8, 8, 0);
        n_x0 = 10; n_y0 = 4; n_w = 9; n_h = 9; n_dec = 2;
        drive_frame(1'b1, -1, 5);
        exp_frames++;
        nb = pix_diff(msg);
        n_checks++;
        if (nb !== 0) $display("FAIL window_change_old: %s", msg);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
        set_win(n_x0, n_y0, n_w, n_h, n_dec);
        drive_frame(1'b1, -1, -1);
        exp_frames++;
        nb = pix_diff(msg);
        n_checks++;
        if (nb !== 0) $display("FAIL window_change_new: %s", msg);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        string msg;
        int nb;
        for (int f = 0; f < 6; f++) begin
            set_win(int'($urandom_range(0, 28)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 3)));
            drive_frame(1'b1, -1, -1);
            exp_frames++;
            last_cnt = exp_q.size();
            nb = pix_diff(msg);
            n_checks++;
            if (nb !== 0) $display("FAIL random_frame_%0d: win=(%0d,%0d,%0d,%0d,dec%0d) %s",
                                   f, m_x0, m_y0, m_w, m_h, m_dec, msg);
            else n_pass++;
            n_checks++;
            if (oFrame_Cont !== FRM_W'(exp_frames) || oFRAME_PIX !== 32'(stats_exp(last_cnt)))
                $display("FAIL random_counts_%0d: got frm=%0d pix=%0d want frm=%0d pix=%0d",
                         f, oFrame_Cont, oFRAME_PIX, exp_frames, stats_exp(last_cnt));
            else n_pass++;
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_stop();
        string msg;
        int nb;
        set_win(0, 0, FW, FH, 0);
        drive_frame(1'b1, 5, -1);
        exp_frames++;
        nb = pix_diff(msg);
        n_checks++;
        if (nb !== 0) $display("FAIL stop_frame_completes: %s", msg);
        else n_pass++;
        n_checks++;
        if (oFrame_Cont !== FRM_W'(exp_frames) || oBUSY !== 1'b0)
            $display("FAIL stop_idle: got frm=%0d busy=%b want frm=%0d busy=0", oFrame_Cont, oBUSY, exp_frames);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
        drive_frame(1'b0, -1, -1);
        n_checks++;
        if (obs_q.size() != 0 || oFrame_Cont !== FRM_W'(exp_frames))
            $display("FAIL after_stop: got %0d pixels frm=%0d want 0 pixels frm=%0d",
                     obs_q.size(), oFrame_Cont, exp_frames);
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_start_end_same();
        iSTART = 1'b1; iEND = 1'b1;
        step();
        step();
        n_checks++;
        if (oBUSY !== 1'b0) $display("FAIL start_end_same_busy: got %b want 0", oBUSY);
        else n_pass++;
        iSTART = 1'b0; iEND = 1'b0;
        drive_frame(1'b0, -1, -1);
        n_checks++;
        if (obs_q.size() != 0 || oFrame_Cont !== FRM_W'(exp_frames))
            $display("FAIL start_end_same_frame: got %0d pixels frm=%0d want 0 pixels frm=%0d",
                     obs_q.size(), oFrame_Cont, exp_frames);
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_zero_width();
        arm();
        set_win(0, 0, 0, FH, 0);
        drive_frame(1'b1, -1, -1);
        exp_frames++;
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || oFrame_Cont !== FRM_W'(exp_frames) || oFRAME_PIX !== 32'd0)
            $display("FAIL zero_width: got %0d pixels frm=%0d pix=%0d want 0 pixels frm=%0d pix=0",
                     obs_q.size(), oFrame_Cont, oFRAME_PIX, exp_frames);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        set_win(0, 0, FW, FH, 0);
        step(); iFVAL = 1'b1;
        step();
        for (int x = 0; x < 6; x++) begin
            step(); iLVAL = 1'b1; iDATA = DATA_W'($urandom);
        end
        step();
        iRST = 1'b1;
        #1;
        n_checks++;
        if ({oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY, oFRAME_PIX} !== '0)
            $display("FAIL reset_mid_outputs: got dval=%b data=%h x=%0d frm=%0d busy=%b pix=%0d want all 0",
                     oDVAL, oDATA, oX_Cont, oFrame_Cont, oBUSY, oFRAME_PIX);
        else n_pass++;
        exp_frames = 0;
        iLVAL = 1'b0; iFVAL = 1'b0;
        step();
        iRST = 1'b0;
        step();
        obs_q.delete();
        drive_frame(1'b0, -1, -1);
        n_checks++;
        if (obs_q.size() != 0 || oFrame_Cont !== 0 || oBUSY !== 1'b0)
            $display("FAIL reset_mid_no_resume: got %0d pixels frm=%0d busy=%b want 0 pixels frm=0 busy=0",
                     obs_q.size(), oFrame_Cont, oBUSY);
        else n_pass++;
        obs_q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        exp_frames = 0;
        n_x0 = 0; n_y0 = 0; n_w = 0; n_h = 0; n_dec = 0;
        test_reset();
        test_arm_mid_frame();
        test_window_dec();
        test_window_change();
        test_back_to_back();
        test_stop();
        test_start_end_same();
        test_zero_width();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
